sha1_pad: RTL and testbench
===========================

SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 Parameters: none; the bit-length field is fixed at 64 bits per FIPS 180-4.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 byte_i  input  8  message byte, in message order.
REQ-005 byte_valid_i  input  1  byte_i valid.
REQ-006 byte_last_i  input  1  byte_i is final byte of message; qualified by byte_valid_i.
REQ-007 byte_ready_o  output  1  padder accepts byte_i this cycle.
REQ-008 block_o  output  512  padded block; message byte 0 at bits [511:504] (big-endian), directly drivable into sha1_block block_i.
REQ-009 block_valid_o  output  1  block_o valid.
REQ-010 block_first_o  output  1  block is first of message; consumer seeds from sha1_head.
REQ-011 block_last_o  output  1  block is final of message; consumer's chained H is the digest.
REQ-012 block_ready_i  input  1  consumer accepts block_o.

Function
REQ-013 A byte transfer occurs on byte_valid_i && byte_ready_o; a block transfer occurs on block_valid_o && block_ready_i.
REQ-014 States: FILL, PAD, EMIT; byte_ready_o = 1 only in FILL; block_valid_o = 1 only in EMIT.
REQ-015 FILL: accepted byte written to buffer byte index cnt (7-bit, 0..64); cnt increments; 61-bit message byte counter increments, wrapping modulo 2^61.
REQ-016 FILL: byte_last_i accepted -> PAD next cycle; else 64th byte accepted -> EMIT next cycle, block_last_o = 0.
REQ-017 PAD (one cycle), c = cnt: c<=55 -> byte c = 0x80, bytes c+1..55 = 0x00, bytes 56..63 = bit length (bytes x 8) big-endian, EMIT with last=1.
REQ-018 PAD, 56<=c<=63 -> byte c = 0x80, bytes c+1..63 = 0x00, EMIT with last=0, extra pending with marker=0.
REQ-019 PAD, c=64 -> buffer unchanged, EMIT with last=0, extra pending with marker=1.
REQ-020 EMIT, transfer with extra pending -> buffer reloaded as byte 0 = (marker ? 0x80 : 0x00), bytes 1..55 = 0x00, bytes 56..63 = bit length; remain in EMIT with last=1; extra cleared.
REQ-021 EMIT, transfer without extra pending -> FILL, cnt = 0; if block was last, message counter cleared and first flag set.
REQ-022 block_first_o set for first block emitted after reset or after a last block; cleared after that block transfers.
REQ-023 While block_valid_o && !block_ready_i, block_o, block_first_o, and block_last_o hold stable.
REQ-024 Latency: non-last full block valid 1 cycle after 64th byte accepted; final (or penultimate) block valid 2 cycles after last byte accepted.
REQ-025 Zero-length messages are not supported; every message carries at least one byte.
REQ-026 Bit length = byte counter << 3, truncated to 64 bits.

Reset
REQ-027 rst_ni low -> state FILL, cnt = 0, byte counter = 0, first flag = 1, extra and marker = 0, buffer = 0.
REQ-028 Reset outputs: byte_ready_o = 1 once released, block_valid_o = 0, block_first_o = 1, block_last_o = 0, block_o = 0.
REQ-029 Reset mid-message or mid-EMIT discards all partial data; the next accepted byte starts a new message.

Structure
REQ-030 Shared package sha1_pkg holds: state enum (FILL, PAD, EMIT), SHA1_PAD_BYTE = 8'h80, SHA1_LEN_OFS = 56, SHA1_BLOCK_BYTES = 64.
REQ-031 No sub-module; buffer, counters, and FSM are inline; downstream pairing is with sha1_head/sha1_block.

Verification
REQ-032 "abc" (0x61,0x62,0x63, last on 0x63) -> one block 61626380 00.. 00000000_00000018, first=1, last=1.
REQ-033 55 bytes 0x00 -> one block, byte 55 = 0x80, length 0x1B8, first=last=1.
REQ-034 56 bytes 0x41 -> block 1: byte 56 = 0x80, rest 0, last=0; block 2: all zero except length 0x1C0, first=0, last=1.
REQ-035 64 bytes 0x00 -> block 1: raw data, first=1, last=0; block 2: byte 0 = 0x80, length 0x200, last=1.
REQ-036 "abc" with block_ready_i low 5 cycles -> block_o/flags stable, byte_ready_o = 0 throughout; single transfer on release.
REQ-037 rst_ni pulsed after 30 bytes, then "abc" sent -> output identical to REQ-032 with first=1.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder FSM states and message-block geometry.
package sha1_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } sha1_pad_state_e;

    localparam logic [7:0] SHA1_PAD_BYTE    = 8'h80;
    localparam int         SHA1_LEN_OFS     = 56;
    localparam int         SHA1_BLOCK_BYTES = 64;

endpackage

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs bytes big-endian into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length, spilling into an extra block when needed.
//
// state | meaning
// FILL  | accepting message bytes into the block buffer
// PAD   | one cycle: write marker, zero fill and (if it fits) the length field
// EMIT  | block_o offered downstream until transferred
module sha1_pad
    import sha1_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    input  logic         byte_last_i,
    output logic         byte_ready_o,
    output logic [511:0] block_o,
    output logic         block_valid_o,
    output logic         block_first_o,
    output logic         block_last_o,
    input  logic         block_ready_i
);

    localparam logic [6:0] CNT_FULL = 7'(SHA1_BLOCK_BYTES);
    localparam logic [6:0] LEN_OFS  = 7'(SHA1_LEN_OFS);

    sha1_pad_state_e state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [60:0]     msg_cnt_q, msg_cnt_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            extra_q, extra_d;
    logic            marker_q, marker_d;
    logic [511:0]    buf_q, buf_d;
    logic [63:0]     bit_len;

    assign bit_len = {msg_cnt_q, 3'b000};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        msg_cnt_d = msg_cnt_q;
        first_d   = first_q;
        last_d    = last_q;
        extra_d   = extra_q;
        marker_d  = marker_q;
        buf_d     = buf_q;

        case (state_q)
            FILL: begin
                if (byte_valid_i) begin
                    for (int i = 0; i < SHA1_BLOCK_BYTES; i++) begin
                        if (cnt_q == 7'(i)) buf_d[511-8*i -: 8] = byte_i;
                    end
                    cnt_d     = cnt_q + 7'd1;
                    msg_cnt_d = msg_cnt_q + 61'd1;
                    if (byte_last_i) begin
                        state_d = PAD;
                    end else if (cnt_q == CNT_FULL - 7'd1) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                    end
                end
            end

            PAD: begin
                state_d = EMIT;
                last_d  = 1'b0;
                if (cnt_q == CNT_FULL) begin
                    // Full block ended the message: it goes out untouched and the
                    // marker moves to the start of the extra block.
                    extra_d  = 1'b1;
                    marker_d = 1'b1;
                end else begin
                    for (int i = 0; i < SHA1_BLOCK_BYTES; i++) begin
                        if (cnt_q == 7'(i)) begin
                            buf_d[511-8*i -: 8] = SHA1_PAD_BYTE;
                        end else if (7'(i) > cnt_q &&
                                     (i < SHA1_LEN_OFS || cnt_q >= LEN_OFS)) begin
                            buf_d[511-8*i -: 8] = 8'h00;
                        end
                    end
                    if (cnt_q < LEN_OFS) begin
                        buf_d[63:0] = bit_len;
                        last_d      = 1'b1;
                    end else begin
                        extra_d  = 1'b1;
                        marker_d = 1'b0;
                    end
                end
            end

            EMIT: begin
                if (block_ready_i) begin
                    first_d = 1'b0;
                    if (extra_q) begin
                        buf_d          = '0;
                        buf_d[511:504] = marker_q ? SHA1_PAD_BYTE : 8'h00;
                        buf_d[63:0]    = bit_len;
                        last_d         = 1'b1;
                        extra_d        = 1'b0;
                        marker_d       = 1'b0;
                    end else begin
                        state_d = FILL;
                        cnt_d   = '0;
                        if (last_q) begin
                            msg_cnt_d = '0;
                            first_d   = 1'b1;
                        end
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            msg_cnt_q <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            extra_q   <= 1'b0;
            marker_q  <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            msg_cnt_q <= msg_cnt_d;
            first_q   <= first_d;
            last_q    <= last_d;
            extra_q   <= extra_d;
            marker_q  <= marker_d;
            buf_q     <= buf_d;
        end
    end

    assign byte_ready_o  = (state_q == FILL);
    assign block_valid_o = (state_q == EMIT);
    assign block_o       = buf_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: hand-computed padded blocks for boundary message lengths.
module tb_sha1_pad;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [7:0]   byte_i = '0;
    logic         byte_valid_i = 1'b0;
    logic         byte_last_i = 1'b0;
    logic         byte_ready_o;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_first_o;
    logic         block_last_o;
    logic         block_ready_i = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    sha1_pad dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .block_ready_i (block_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one byte from a negedge and hold it until the padder accepts it.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int k;
        @(negedge clk_i);
        byte_i       = b;
        byte_valid_i = 1'b1;
        byte_last_i  = last;
        k = 0;
        while (!byte_ready_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 200) chk("byte_ready_timeout", 512'(k), 512'(0));
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic send_fill(input logic [7:0] b, input int n, input logic with_last);
        for (int i = 0; i < n; i++) send_byte(b, with_last && (i == n - 1));
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    // Wait for a block, check it (and its latency in cycles when lat > 0), then take it.
    task automatic take_block(input string tag, input logic [511:0] exp,
                              input logic first, input logic last, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!block_valid_o && n < 50);
        if (!block_valid_o) begin
            chk({tag, "_timeout"}, 512'(block_valid_o), 512'(1));
        end else begin
            if (lat > 0) chk({tag, "_lat"}, 512'(n), 512'(lat));
            chk({tag, "_block"}, block_o, exp);
            chk({tag, "_first"}, 512'(block_first_o), 512'(first));
            chk({tag, "_last"}, 512'(block_last_o), 512'(last));
            block_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            block_ready_i = 1'b0;
        end
    endtask

    logic [511:0] abc_blk;

    initial begin
        abc_blk = {32'h61626380, 416'h0, 64'h18};

        #12;
        chk("rst_ready_low", 512'(byte_ready_o), 512'(1));
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", 512'(byte_ready_o), 512'(1));
        chk("rst_valid", 512'(block_valid_o), 512'(0));
        chk("rst_first", 512'(block_first_o), 512'(1));
        chk("rst_last", 512'(block_last_o), 512'(0));
        chk("rst_block", block_o, 512'(0));

        send_abc();
        take_block("abc", abc_blk, 1'b1, 1'b1, 2);
        @(negedge clk_i);
        chk("abc_done_valid", 512'(block_valid_o), 512'(0));
        chk("abc_done_ready", 512'(byte_ready_o), 512'(1));

        send_fill(8'h00, 55, 1'b1);
        take_block("len55", {440'h0, 8'h80, 64'h1B8}, 1'b1, 1'b1, 2);

        send_fill(8'h41, 56, 1'b1);
        take_block("len56_b1", {{56{8'h41}}, 8'h80, 56'h0}, 1'b1, 1'b0, 2);
        take_block("len56_b2", {448'h0, 64'h1C0}, 1'b0, 1'b1, 1);

        send_fill(8'h00, 64, 1'b1);
        take_block("len64_b1", 512'h0, 1'b1, 1'b0, 2);
        take_block("len64_b2", {8'h80, 440'h0, 64'h200}, 1'b0, 1'b1, 1);

        // 65-byte message: full non-last block appears one cycle after byte 64.
        send_fill(8'h5A, 64, 1'b0);
        take_block("len65_b1", {64{8'h5A}}, 1'b1, 1'b0, 1);
        send_byte(8'hA5, 1'b1);
        take_block("len65_b2", {8'hA5, 8'h80, 432'h0, 64'h208}, 1'b0, 1'b1, 2);

        // Backpressure: block and flags must hold while the consumer stalls.
        send_abc();
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!block_valid_o && n < 50);
            chk("stall_valid", 512'(block_valid_o), 512'(1));
            for (int c = 0; c < 5; c++) begin
                chk("stall_block", block_o, abc_blk);
                chk("stall_first", 512'(block_first_o), 512'(1));
                chk("stall_last", 512'(block_last_o), 512'(1));
                chk("stall_byte_ready", 512'(byte_ready_o), 512'(0));
                chk("stall_hold_valid", 512'(block_valid_o), 512'(1));
                @(negedge clk_i);
            end
            block_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            block_ready_i = 1'b0;
            @(negedge clk_i);
            chk("stall_single_xfer", 512'(block_valid_o), 512'(0));
            chk("stall_ready_back", 512'(byte_ready_o), 512'(1));
        end

        // Reset mid-message discards the partial block and length.
        send_fill(8'h33, 30, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_valid", 512'(block_valid_o), 512'(0));
        chk("midrst_block", block_o, 512'(0));
        chk("midrst_first", 512'(block_first_o), 512'(1));
        rst_ni = 1'b1;
        send_abc();
        take_block("post_rst_abc", abc_blk, 1'b1, 1'b1, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
